// File: rtl/io_pwm_pkg.sv
// io_pwm_pkg: shared constants and types for the io_pwm block.
//   Register byte offsets inside the 32-byte window, CTRL bit positions,
//   counter width, channel count and the CTRL register layout.
package io_pwm_pkg;

  localparam int CNT_W  = 16;  // prescale / period counter and duty width
  localparam int NUM_CH = 2;   // PWM channels

  // byte offsets within the register window
  localparam logic [4:0] OFS_CTRL     = 5'h00;
  localparam logic [4:0] OFS_PRESCALE = 5'h04;
  localparam logic [4:0] OFS_PERIOD   = 5'h08;
  localparam logic [4:0] OFS_DUTY0    = 5'h0C;
  localparam logic [4:0] OFS_DUTY1    = 5'h10;
  localparam logic [4:0] OFS_STATUS   = 5'h14;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_INV0   = 2;
  localparam int CTRL_INV1   = 3;
  localparam int CTRL_W      = 4;

  // CTRL layout, MSB first so bit CTRL_EN lands at [0]
  typedef struct packed {
    logic [1:0] inv;     // [CTRL_INV1:CTRL_INV0]
    logic       irq_en;  // [CTRL_IRQ_EN]
    logic       en;      // [CTRL_EN]
  } ctrl_t;

  // byte offset of a word address inside the window
  function automatic logic [4:0] word_ofs(input logic [2:0] wsel);
    return {wsel, 2'b00};
  endfunction

endpackage

// File: rtl/io_pwm_compare.sv
// pwm_compare: one PWM channel.
//   Holds the shadow duty (reloaded only at period wrap or while disabled so
//   a duty write never truncates or stretches the running period), the
//   registered compare and the output inversion.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   enable         CTRL enable
//   period_zero    PERIOD == 0, forces the raw output low
//   wrap           period wrap strobe, shadow reload point
//   duty           live DUTYn register
//   cnt            period counter
//   inv            CTRL invn
//   pwm            channel output (raw ^ inv)
module pwm_compare
  import io_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             period_zero,
  input  logic             wrap,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] cnt,
  input  logic             inv,
  output logic             pwm
);

  logic [CNT_W-1:0] shadow_q;
  logic             raw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      raw_q    <= 1'b0;
    end else begin
      if (!enable || wrap) shadow_q <= duty;
      // counter never exceeds PERIOD, so DUTY > PERIOD stays high all period
      raw_q <= enable && !period_zero && (cnt < shadow_q);
    end
  end

  assign pwm = raw_q ^ inv;

endmodule

// File: rtl/io_pwm.sv
// io_pwm: two-channel PWM on the dma_io register bus.
//   Registers (byte offset from BASE_ADR): 0x00 CTRL{inv1,inv0,irq_en,en},
//   0x04 PRESCALE, 0x08 PERIOD, 0x0C DUTY0, 0x10 DUTY1, 0x14 STATUS{wrap}.
//   Read data is chained: a window hit replaces dma_io_rdata_in, otherwise
//   it passes through.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   dma_io_we/wadr/wdata             IO write
//   dma_io_radr/radr_en              IO read address / enable
//   dma_io_rdata_in / dma_io_rdata   read chain in / out
//   pwm_o[1:0]                       channel outputs
//   pwm_irq_1shot                    one-cycle pulse the cycle after a wrap
module io_pwm
  import io_pwm_pkg::*;
#(
  parameter logic [15:0] BASE_ADR = 16'hC800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_io_we,
  input  logic [15:2]       dma_io_wadr,
  input  logic [31:0]       dma_io_wdata,
  input  logic [15:2]       dma_io_radr,
  input  logic              dma_io_radr_en,
  input  logic [31:0]       dma_io_rdata_in,
  output logic [31:0]       dma_io_rdata,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              pwm_irq_1shot
);

  ctrl_t                         ctrl_q;
  logic [CNT_W-1:0]              prescale_q, period_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  duty_q;
  logic                          wrap_flag_q;
  logic [CNT_W-1:0]              pre_cnt_q, per_cnt_q;
  logic                          irq_q;

  logic       wr_hit, rd_hit, status_clr;
  logic [4:0] wr_ofs, rd_ofs;
  logic       tick, wrap, period_zero;
  logic       unused_wdata;

  assign wr_hit = dma_io_we      && (dma_io_wadr[15:5] == BASE_ADR[15:5]);
  assign rd_hit = dma_io_radr_en && (dma_io_radr[15:5] == BASE_ADR[15:5]);
  assign wr_ofs = word_ofs(dma_io_wadr[4:2]);
  assign rd_ofs = word_ofs(dma_io_radr[4:2]);
  assign unused_wdata = ^dma_io_wdata[31:CNT_W];

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      period_q   <= '0;
      duty_q     <= '0;
    end else if (wr_hit) begin
      case (wr_ofs)
        OFS_CTRL:     ctrl_q     <= ctrl_t'(dma_io_wdata[CTRL_W-1:0]);
        OFS_PRESCALE: prescale_q <= dma_io_wdata[CNT_W-1:0];
        OFS_PERIOD:   period_q   <= dma_io_wdata[CNT_W-1:0];
        OFS_DUTY0:    duty_q[0]  <= dma_io_wdata[CNT_W-1:0];
        OFS_DUTY1:    duty_q[1]  <= dma_io_wdata[CNT_W-1:0];
        default:      ;
      endcase
    end
  end

  // sticky wrap flag, write-1-to-clear; a simultaneous wrap keeps it set
  assign status_clr = wr_hit && (wr_ofs == OFS_STATUS) && dma_io_wdata[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wrap_flag_q <= 1'b0;
    else if (wrap)       wrap_flag_q <= 1'b1;
    else if (status_clr) wrap_flag_q <= 1'b0;
  end

  // ---------------- counters ----------------
  // >= instead of == so a PRESCALE/PERIOD shrunk below the running count
  // terminates at once instead of running through the full 16-bit range
  assign period_zero = (period_q == '0);
  assign tick        = ctrl_q.en && (pre_cnt_q >= prescale_q);
  assign wrap        = tick && !period_zero && (per_cnt_q >= period_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      per_cnt_q <= '0;
    end else if (!ctrl_q.en) begin
      pre_cnt_q <= '0;
      per_cnt_q <= '0;
    end else begin
      pre_cnt_q <= tick ? '0 : pre_cnt_q + CNT_W'(1);
      if (tick) per_cnt_q <= (period_zero || wrap) ? '0 : per_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= wrap && ctrl_q.irq_en;
  end

  assign pwm_irq_1shot = irq_q;

  // ---------------- channels ----------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_compare u_cmp (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (ctrl_q.en),
      .period_zero (period_zero),
      .wrap        (wrap),
      .duty        (duty_q[g]),
      .cnt         (per_cnt_q),
      .inv         (ctrl_q.inv[g]),
      .pwm         (pwm_o[g])
    );
  end

  // ---------------- read chain ----------------
  always_comb begin
    dma_io_rdata = dma_io_rdata_in;
    if (rd_hit) begin
      case (rd_ofs)
        OFS_CTRL:     dma_io_rdata = 32'(ctrl_q);
        OFS_PRESCALE: dma_io_rdata = 32'(prescale_q);
        OFS_PERIOD:   dma_io_rdata = 32'(period_q);
        OFS_DUTY0:    dma_io_rdata = 32'(duty_q[0]);
        OFS_DUTY1:    dma_io_rdata = 32'(duty_q[1]);
        OFS_STATUS:   dma_io_rdata = 32'(wrap_flag_q);
        default:      dma_io_rdata = '0;
      endcase
    end
  end

endmodule
